// File: rtl/spi_slave_endpoint.sv
// SPI slave endpoint (CPOL=0, CPHA=1, MSB first) with all SPI pins resynchronised into clk.
// The master's frame is latched into data_out on cs release; a short frame is flagged as an error.
module spi_slave_endpoint #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  frame_done,
  output logic                  frame_error,
  input  logic                  sclk,
  input  logic                  cs,
  input  logic                  mosi,
  output logic                  miso
);

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;
  // Fills with ones after reset; cs edges count only once the chain holds real pin samples.
  logic [SYNC_STAGES:0]   fill_q;

  logic sclk_s, cs_s, mosi_s, sync_valid;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s     = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s       = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
  assign sync_valid = fill_q[SYNC_STAGES];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = sync_valid & ~cs_s & cs_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      fill_q      <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, data_out_q, data_out_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  miso_q, miso_d, done_q, done_d, error_q, error_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tx_q       <= '0;
      rx_q       <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
      miso_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      miso_q     <= miso_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // cs edges take priority over an sclk edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    miso_d     = miso_q;
    done_d     = 1'b0;
    error_d    = 1'b0;
    case (state_q)
      StIdle: begin
        miso_d = 1'b0;
        if (cs_fall) begin
          tx_d    = data_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (cs_rise) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else if (sclk_rise) begin
          miso_d = tx_q[DATA_WIDTH-1];
          tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
        end else if (sclk_fall) begin
          rx_d  = {rx_q[DATA_WIDTH-2:0], mosi_s};
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) state_d = StDone;
        end
      end
      StDone: begin
        if (cs_rise) begin
          data_out_d = rx_q;
          done_d     = 1'b1;
          state_d    = StIdle;
        end else if (sclk_rise) begin
          miso_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign data_out    = data_out_q;
  assign ready       = (state_q == StIdle);
  assign frame_done  = done_q;
  assign frame_error = error_q;
  assign miso        = miso_q;

endmodule

// File: tb/tb_spi_slave_endpoint.sv
// Directed bench for spi_slave_endpoint (DATA_WIDTH=8): full, back-to-back, aborted,
// over-long and reset-interrupted frames, with pulse latency checked on cs release.
module tb_spi_slave_endpoint;

  logic       clk = 1'b0;
  logic       rst, sclk, cs, mosi;
  logic [7:0] data_in;
  logic [7:0] data_out;
  logic       ready, frame_done, frame_error, miso;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0;
  int d0, e0;
  logic [15:0] cap, cap2;
  logic [15:0] word;

  spi_slave_endpoint #(
    .DATA_WIDTH (8),
    .SYNC_STAGES(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .data_in    (data_in),
    .data_out   (data_out),
    .ready      (ready),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .sclk       (sclk),
    .cs         (cs),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (frame_error) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // sclk half-period is 4 clk; master drives mosi on rise and samples miso before the fall.
  task automatic spi_bits(input int n, input logic [15:0] bits, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1;
      mosi = bits[15-i];
      #40;
      got  = {got[14:0], miso};
      sclk = 1'b0;
      #40;
    end
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1 cs = 1'b0;
    #40;
  endtask

  // Releases cs just after a clk edge; the result must appear on the 3rd edge, not the 2nd.
  task automatic end_frame(input string tag, input logic exp_done, input logic exp_err,
                           input logic [7:0] exp_data);
    @(posedge clk);
    #1 cs = 1'b1;
    repeat (3) @(negedge clk);
    check({tag, "_early"}, 32'({frame_done, frame_error}), 32'(2'b00));
    @(negedge clk);
    check({tag, "_pulse"}, 32'({frame_done, frame_error}), 32'({exp_done, exp_err}));
    check({tag, "_data"}, 32'(data_out), 32'(exp_data));
    @(negedge clk);
    check({tag, "_pulse_end"}, 32'({frame_done, frame_error}), 32'(2'b00));
    check({tag, "_ready"}, 32'(ready), 32'(1));
    repeat (4) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(ready), 32'(1));
    check("rst_data_out", 32'(data_out), 32'(0));
    check("rst_miso", 32'(miso), 32'(0));
    check("rst_pulses", 32'({frame_done, frame_error}), 32'(0));
    repeat (4) @(negedge clk);

    // Full frame
    d0 = done_cnt; e0 = err_cnt;
    data_in = 8'hA5;
    start_frame();
    check("t1_busy", 32'(ready), 32'(0));
    spi_bits(8, {8'h3C, 8'h00}, cap);
    check("t1_miso", 32'(cap[7:0]), 32'(8'hA5));
    #40;
    end_frame("t1", 1'b1, 1'b0, 8'h3C);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'(1));
    check("t1_err_cnt", 32'(err_cnt - e0), 32'(0));

    // Back-to-back frames, data_in disturbed mid-frame
    d0 = done_cnt; e0 = err_cnt;
    data_in = 8'hC3;
    word = {8'h01, 8'h00};
    start_frame();
    spi_bits(3, word, cap);
    data_in = 8'h00;
    spi_bits(5, word << 3, cap2);
    check("t2a_miso", 32'({cap[2:0], cap2[4:0]}), 32'(8'hC3));
    #40;
    end_frame("t2a", 1'b1, 1'b0, 8'h01);
    data_in = 8'h5E;
    start_frame();
    spi_bits(8, {8'hFF, 8'h00}, cap);
    check("t2b_miso", 32'(cap[7:0]), 32'(8'h5E));
    #40;
    end_frame("t2b", 1'b1, 1'b0, 8'hFF);
    check("t2_done_cnt", 32'(done_cnt - d0), 32'(2));
    check("t2_err_cnt", 32'(err_cnt - e0), 32'(0));

    // Abort after 5 sclk cycles
    d0 = done_cnt; e0 = err_cnt;
    data_in = 8'hB0;
    start_frame();
    spi_bits(5, {8'h96, 8'h00}, cap);
    check("t3_miso", 32'(cap[4:0]), 32'(5'b10110));
    #40;
    end_frame("t3", 1'b0, 1'b1, 8'hFF);
    check("t3_done_cnt", 32'(done_cnt - d0), 32'(0));
    check("t3_err_cnt", 32'(err_cnt - e0), 32'(1));

    // Ten sclk cycles; the two extra ones carry mosi=1 and must be ignored
    data_in = 8'hFF;
    start_frame();
    spi_bits(10, 16'h81C0, cap);
    check("t4_miso", 32'(cap[9:0]), 32'(10'h3FC));
    #40;
    end_frame("t4", 1'b1, 1'b0, 8'h81);

    // Reset mid-frame with cs held low through release
    d0 = done_cnt; e0 = err_cnt;
    data_in = 8'hAA;
    start_frame();
    spi_bits(3, {8'hF0, 8'h00}, cap);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_ready", 32'(ready), 32'(1));
    check("t5_data_out", 32'(data_out), 32'(0));
    @(posedge clk);
    #1 cs = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_pulses", 32'({done_cnt - d0, err_cnt - e0}), 32'(0));
    data_in = 8'hC3;
    start_frame();
    spi_bits(8, {8'h5A, 8'h00}, cap);
    check("t5_miso", 32'(cap[7:0]), 32'(8'hC3));
    #40;
    end_frame("t5", 1'b1, 1'b0, 8'h5A);

    // cs toggle without any sclk edge
    d0 = done_cnt; e0 = err_cnt;
    start_frame();
    #60;
    end_frame("t6", 1'b0, 1'b1, 8'h5A);
    check("t6_done_cnt", 32'(done_cnt - d0), 32'(0));
    check("t6_err_cnt", 32'(err_cnt - e0), 32'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_slave_endpoint.md
SPI_SLAVE_ENDPOINT -- requirements
Module: spi_slave_endpoint

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, frame length in bits (≥2).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, depth of input synchronizer chains (≥2).
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port data_in  input  DATA_WIDTH  word sent to master in next frame.
REQ-006 SHALL have port data_out  output  DATA_WIDTH  last complete word received from master.
REQ-007 SHALL have port ready  output  1  high when no frame in progress (IDLE).
REQ-008 SHALL have port frame_done  output  1  one-cycle pulse, complete frame received.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse, frame aborted short.
REQ-010 SHALL have port sclk  input  1  SPI clock from master, asynchronous to clk.
REQ-011 SHALL have port cs  input  1  SPI chip select, active-low, asynchronous to clk.
REQ-012 SHALL have port mosi  input  1  serial data from master.
REQ-013 SHALL have port miso  output  1  serial data to master.

Function
REQ-014 SHALL implement SPI mode CPOL=0, CPHA=1, MSB first: drive miso on sclk rising edge, sample mosi on sclk falling edge.
REQ-015 SHALL pass sclk, cs, mosi each through a SYNC_STAGES-flop synchronizer plus one previous-value register; edges = synced vs previous value.
REQ-016 SHALL require sclk high and low phases ≥3 clk periods; behaviour outside this is undefined.
REQ-017 SHALL use states IDLE, SHIFT, DONE.
REQ-018 IDLE: on cs falling edge -> tx shift register <= data_in, bit counter <= 0, state SHIFT; miso held 0.
REQ-019 SHIFT: on sclk rising edge -> miso <= tx MSB, tx register shifts left (fill 0).
REQ-020 SHIFT: on sclk falling edge -> rx register <= {rx[DATA_WIDTH-2:0], synced mosi}, counter +1; at DATA_WIDTH-th falling edge -> DONE.
REQ-021 DONE: further sclk edges ignored; miso <= 0 on next sclk rising edge.
REQ-022 cs rising edge in DONE -> data_out <= rx register, frame_done pulses one cycle, state IDLE.
REQ-023 cs rising edge in SHIFT -> frame_error pulses one cycle, data_out unchanged, state IDLE.
REQ-024 cs rising edge in IDLE ignored; no pulses.
REQ-025 cs edge and sclk edge detected same cycle: cs edge handled, sclk edge discarded.
REQ-026 data_in sampled only at cs falling edge; later changes do not affect current frame.
REQ-027 ready SHALL be high exactly when state is IDLE.
REQ-028 Latency: frame_done/data_out update SHALL appear SYNC_STAGES+1 clk cycles after cs pin rises (sampled); miso update same latency after sclk pin rises.
REQ-029 Bit counter SHALL be $clog2(DATA_WIDTH+1) bits wide, no wrap.

Reset
REQ-030 On rst: state IDLE, data_out 0, ready 1, frame_done 0, frame_error 0, miso 0, shift registers 0, counter 0, synchronizers 1 for cs, 0 for sclk/mosi.
REQ-031 Reset mid-frame SHALL abort silently (no frame_error); a new frame starts only on a subsequent cs falling edge.
REQ-032 cs held low through reset release SHALL not start a frame.

Verification (DATA_WIDTH=8, SYNC_STAGES=2, sclk half-period 4 clk)
REQ-033 Full frame, data_in=8'hA5, master sends 8'h3C -> miso bits 1,0,1,0,0,1,0,1; after cs rise data_out=8'h3C, one frame_done pulse, ready returns 1.
REQ-034 Back-to-back frames 8'h01 then 8'hFF with data_in changed mid-frame 1 -> frame 1 miso unaffected; data_out 8'h01 then 8'hFF; two frame_done pulses.
REQ-035 Abort after 5 sclk cycles -> frame_error pulse once, data_out keeps previous value, no frame_done.
REQ-036 10 sclk cycles in one frame (master 8'h81 first) -> extra edges ignored, miso 0 after bit 8, data_out=8'h81.
REQ-037 rst asserted after 3 bits, cs still low, then released -> ready 1, no pulses; later cs high/low frame of 8'h5A received correctly.
REQ-038 cs toggle with no sclk edges -> frame_error pulse, data_out unchanged.
